wb_victim_cache: RTL and testbench

Parametrised, fully associative victim cache between the write-back L1 data cache and the memory interface. It holds lines evicted from L1, clean or dirty, and serves L1 misses by swapping a hit line back to L1. Entries displaced from a full cache are written back to memory through a one-entry writeback buffer when dirty, and discarded when clean. A flush drains every dirty entry to memory.

---
 rtl/vcache_pkg.sv | 13 +
 rtl/vc_match.sv | 22 ++
 rtl/wb_victim_cache.sv | 150 +++++++++++++++
 tb/tb_wb_victim_cache.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vcache_pkg.sv
// vcache_pkg: shared defaults, FSM states and entry layout for the victim cache
package vcache_pkg;
  localparam int VC_ENTRIES_DEF = 4;
  localparam int LINE_WIDTH_DEF = 128;
  localparam int LINE_ADDR_W_DEF = 28;
  typedef enum logic [1:0] {IDLE, FLUSH_SCAN, FLUSH_WAIT} type_vc_state_e;
  typedef struct packed {
    logic [LINE_ADDR_W_DEF-1:0] addr;
    logic [LINE_WIDTH_DEF-1:0] data;
    logic valid;
    logic dirty;
  } type_vc_entry_s;
endpackage

// File: rtl/vc_match.sv
// vc_match: parallel address compare over all entries (one-hot, encoded index, any-hit)
module vc_match #(
  parameter int N = 4,
  parameter int AW = 28,
  localparam int IW = $clog2(N)
) (
  input  logic [AW-1:0]        addr_i,
  input  logic [N-1:0][AW-1:0] tags_i,
  input  logic [N-1:0]         valid_i,
  output logic [N-1:0]         match_o,
  output logic [IW-1:0]        idx_o,
  output logic                 hit_o
);
  for (genvar g = 0; g < N; g++) begin : g_cmp
    assign match_o[g] = valid_i[g] && tags_i[g] == addr_i;
  end
  always_comb begin
    idx_o = '0;
    for (int k = 0; k < N; k++) if (match_o[k]) idx_o = IW'(k);
  end
  assign hit_o = |match_o;
endmodule

// File: rtl/wb_victim_cache.sv
// wb_victim_cache: fully associative victim cache with swap-on-hit lookups,
// FIFO replacement, a one-entry writeback buffer and a dirty-line flush.
module wb_victim_cache import vcache_pkg::*; #(
  parameter int VC_ENTRIES = VC_ENTRIES_DEF,
  parameter int LINE_WIDTH = LINE_WIDTH_DEF,
  parameter int LINE_ADDR_W = LINE_ADDR_W_DEF,
  localparam int IW = $clog2(VC_ENTRIES),
  localparam int OW = IW + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   lookup_req_i,
  input  logic [LINE_ADDR_W-1:0] lookup_addr_i,
  output logic                   lookup_hit_o,
  output logic                   lookup_dirty_o,
  output logic [LINE_WIDTH-1:0]  lookup_data_o,
  input  logic                   ins_valid_i,
  output logic                   ins_ready_o,
  input  logic [LINE_ADDR_W-1:0] ins_addr_i,
  input  logic [LINE_WIDTH-1:0]  ins_data_i,
  input  logic                   ins_dirty_i,
  output logic                   wb_valid_o,
  input  logic                   wb_ready_i,
  output logic [LINE_ADDR_W-1:0] wb_addr_o,
  output logic [LINE_WIDTH-1:0]  wb_data_o,
  input  logic                   flush_i,
  output logic                   flush_done_o,
  output logic [OW-1:0]          occupancy_o
);
  localparam int N = VC_ENTRIES;
  type_vc_state_e state_q;
  logic [N-1:0][LINE_ADDR_W-1:0] addr_q;
  logic [N-1:0][LINE_WIDTH-1:0] data_q;
  logic [N-1:0] valid_q, dirty_q, l_match, i_match;
  logic [IW-1:0] ptr_q, idx_q, l_idx, i_idx, free_idx, slot;
  logic wb_valid_q, hit_q, hit_dirty_q, done_q, l_hit, i_hit, any_free;
  logic lk_hit, ins_fire, evict, idle;
  logic [LINE_ADDR_W-1:0] wb_addr_q;
  logic [LINE_WIDTH-1:0] wb_data_q, hit_data_q;
  vc_match #(.N(N), .AW(LINE_ADDR_W)) u_lookup_match (
    .addr_i(lookup_addr_i), .tags_i(addr_q), .valid_i(valid_q),
    .match_o(l_match), .idx_o(l_idx), .hit_o(l_hit)
  );
  vc_match #(.N(N), .AW(LINE_ADDR_W)) u_ins_match (
    .addr_i(ins_addr_i), .tags_i(addr_q), .valid_i(valid_q),
    .match_o(i_match), .idx_o(i_idx), .hit_o(i_hit)
  );
  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (!valid_q[k]) begin
        free_idx = IW'(k);
        any_free = 1'b1;
      end
    end
  end
  assign idle = state_q == IDLE;
  assign lk_hit = idle && lookup_req_i && l_hit;
  assign ins_ready_o = idle && !wb_valid_q;
  assign ins_fire = ins_valid_i && ins_ready_o;
  // Same-address merge beats swap, swap beats a free slot, FIFO victim is last resort.
  assign slot = i_hit ? i_idx : lk_hit ? l_idx : any_free ? free_idx : ptr_q;
  assign evict = !i_hit && !lk_hit && !any_free;
  assign lookup_hit_o = hit_q;
  assign lookup_dirty_o = hit_dirty_q;
  assign lookup_data_o = hit_data_q;
  assign wb_valid_o = wb_valid_q;
  assign wb_addr_o = wb_addr_q;
  assign wb_data_o = wb_data_q;
  assign flush_done_o = done_q;
  assign occupancy_o = OW'($countones(valid_q));
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
      ptr_q <= '0;
      idx_q <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      hit_q <= 1'b0;
      hit_dirty_q <= 1'b0;
      hit_data_q <= '0;
      done_q <= 1'b0;
    end else begin
      hit_q <= lk_hit;
      hit_dirty_q <= lk_hit && |(l_match & dirty_q);
      hit_data_q <= lk_hit ? data_q[l_idx] : '0;
      done_q <= 1'b0;
      if (wb_valid_q && wb_ready_i) begin
        wb_valid_q <= 1'b0;
        wb_addr_q <= '0;
        wb_data_q <= '0;
      end
      if (lk_hit) valid_q <= valid_q & ~l_match;
      if (ins_fire) begin
        valid_q[slot] <= 1'b1;
        addr_q[slot] <= ins_addr_i;
        data_q[slot] <= ins_data_i;
        dirty_q[slot] <= ins_dirty_i || (i_hit && |(i_match & dirty_q));
        if (evict) begin
          ptr_q <= ptr_q + 1'b1;
          if (dirty_q[ptr_q]) begin
            wb_valid_q <= 1'b1;
            wb_addr_q <= addr_q[ptr_q];
            wb_data_q <= data_q[ptr_q];
          end
        end
      end
      case (state_q)
        IDLE: begin
          idx_q <= '0;
          if (flush_i) state_q <= FLUSH_SCAN;
        end
        FLUSH_SCAN: begin
          if (!wb_valid_q) begin
            if (valid_q[idx_q] && dirty_q[idx_q]) begin
              wb_valid_q <= 1'b1;
              wb_addr_q <= addr_q[idx_q];
              wb_data_q <= data_q[idx_q];
              dirty_q[idx_q] <= 1'b0;
              state_q <= FLUSH_WAIT;
            end else if (idx_q == IW'(N - 1)) begin
              valid_q <= '0;
              dirty_q <= '0;
              done_q <= 1'b1;
              state_q <= IDLE;
            end else idx_q <= idx_q + 1'b1;
          end
        end
        FLUSH_WAIT: begin
          if (wb_ready_i) begin
            if (idx_q == IW'(N - 1)) begin
              valid_q <= '0;
              dirty_q <= '0;
              done_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              idx_q <= idx_q + 1'b1;
              state_q <= FLUSH_SCAN;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_victim_cache.sv
// tb_wb_victim_cache: directed and randomized checks against a behavioural entry/queue model
module tb_wb_victim_cache;
  localparam int N = 4, AW = 28, LW = 128, OW = 3;
  logic clk = 1'b0, rst;
  logic lookup_req_i, lookup_hit_o, lookup_dirty_o;
  logic [AW-1:0] lookup_addr_i, ins_addr_i, wb_addr_o;
  logic [LW-1:0] lookup_data_o, ins_data_i, wb_data_o;
  logic ins_valid_i, ins_ready_o, ins_dirty_i, wb_valid_o, wb_ready_i, flush_i, flush_done_o;
  logic [OW-1:0] occupancy_o;
  always #5 clk = ~clk;
  wb_victim_cache #(.VC_ENTRIES(N), .LINE_WIDTH(LW), .LINE_ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .lookup_req_i(lookup_req_i), .lookup_addr_i(lookup_addr_i),
    .lookup_hit_o(lookup_hit_o), .lookup_dirty_o(lookup_dirty_o), .lookup_data_o(lookup_data_o),
    .ins_valid_i(ins_valid_i), .ins_ready_o(ins_ready_o), .ins_addr_i(ins_addr_i),
    .ins_data_i(ins_data_i), .ins_dirty_i(ins_dirty_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
    .flush_i(flush_i), .flush_done_o(flush_done_o), .occupancy_o(occupancy_o)
  );
  int total = 0, bad = 0, hs_count = 0, done_count = 0, m_ptr, fl_cyc;
  logic [AW-1:0] m_addr[N];
  logic [LW-1:0] m_data[N];
  bit m_v[N], m_d[N], flushing, e_hit, e_dirty;
  logic [LW-1:0] e_data;
  logic [AW-1:0] q_addr[$], hs_log[$];
  logic [LW-1:0] q_data[$];
  task automatic chk(string name, logic [LW-1:0] act, logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic clear_entries();
    for (int k = 0; k < N; k++) begin
      m_v[k] = 0;
      m_d[k] = 0;
    end
  endtask
  task automatic model_reset();
    clear_entries();
    m_ptr = 0;
    flushing = 0;
    q_addr.delete();
    q_data.delete();
    e_hit = 0;
    e_dirty = 0;
    e_data = '0;
  endtask
  task automatic step(bit hs, logic [AW-1:0] ha, logic [LW-1:0] hd);
    int li, s;
    bit rdy, c1;
    logic [AW-1:0] ea;
    logic [LW-1:0] ed;
    rdy = !flushing && q_addr.size() == 0;
    if (hs) begin
      hs_count++;
      hs_log.push_back(ha);
      if (q_addr.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wb_unexpected: got addr %0h want no writeback", ha);
      end else begin
        ea = q_addr.pop_front();
        ed = q_data.pop_front();
        chk("wb_hs_addr", LW'(ha), LW'(ea));
        chk("wb_hs_data", hd, ed);
      end
    end
    li = -1;
    if (lookup_req_i && !flushing)
      for (int k = 0; k < N; k++) if (m_v[k] && m_addr[k] == lookup_addr_i) li = k;
    e_hit = li >= 0;
    e_dirty = 0;
    e_data = '0;
    if (e_hit) begin
      e_dirty = m_d[li];
      e_data = m_data[li];
    end
    if (ins_valid_i && rdy) begin
      s = -1;
      c1 = 0;
      for (int k = 0; k < N; k++) if (m_v[k] && m_addr[k] == ins_addr_i) begin s = k; c1 = 1; end
      if (s < 0 && li >= 0) s = li;
      if (s < 0) for (int k = N - 1; k >= 0; k--) if (!m_v[k]) s = k;
      if (s < 0) begin
        s = m_ptr;
        if (m_d[s]) begin
          q_addr.push_back(m_addr[s]);
          q_data.push_back(m_data[s]);
        end
        m_ptr = (m_ptr + 1) % N;
      end
      if (li >= 0) m_v[li] = 0;
      m_d[s] = c1 ? (m_d[s] | ins_dirty_i) : ins_dirty_i;
      m_v[s] = 1;
      m_addr[s] = ins_addr_i;
      m_data[s] = ins_data_i;
    end else if (li >= 0) m_v[li] = 0;
    if (flush_i && !flushing) begin
      flushing = 1;
      fl_cyc = 0;
      for (int k = 0; k < N; k++) if (m_v[k] && m_d[k]) begin
        q_addr.push_back(m_addr[k]);
        q_data.push_back(m_data[k]);
      end
    end
  endtask
  task automatic compare();
    int occ;
    if (flush_done_o) begin
      done_count++;
      total++;
      if (!flushing || q_addr.size() != 0) begin
        bad++;
        $display("FAIL flush_done: got pulse want none (flushing=%0d pending=%0d)", flushing, q_addr.size());
      end
      flushing = 0;
      clear_entries();
    end else if (flushing) begin
      fl_cyc++;
      if (fl_cyc > 300) begin
        total++;
        bad++;
        $display("FAIL flush_timeout: got %0d cycles want <=300", fl_cyc);
        flushing = 0;
        clear_entries();
      end
    end
    occ = 0;
    for (int k = 0; k < N; k++) occ += int'(m_v[k]);
    chk("hit", LW'(lookup_hit_o), LW'(e_hit));
    if (e_hit) begin
      chk("hit_dirty", LW'(lookup_dirty_o), LW'(e_dirty));
      chk("hit_data", lookup_data_o, e_data);
    end
    chk("occupancy", LW'(occupancy_o), LW'(occ));
    chk("ins_ready", LW'(ins_ready_o), LW'(!flushing && q_addr.size() == 0));
    if (!flushing) chk("wb_valid", LW'(wb_valid_o), LW'(q_addr.size() != 0));
    if (wb_valid_o && q_addr.size() != 0) begin
      chk("wb_addr", LW'(wb_addr_o), LW'(q_addr[0]));
      chk("wb_data", wb_data_o, q_data[0]);
    end
    if (!wb_valid_o) begin
      chk("wb_addr_idle", LW'(wb_addr_o), '0);
      chk("wb_data_idle", wb_data_o, '0);
    end
  endtask
  task automatic cyc();
    bit hs;
    logic [AW-1:0] ha;
    logic [LW-1:0] hd;
    #1;
    hs = wb_valid_o && wb_ready_i;
    ha = wb_addr_o;
    hd = wb_data_o;
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else step(hs, ha, hd);
    compare();
  endtask
  task automatic quiet();
    lookup_req_i = 0;
    ins_valid_i = 0;
    flush_i = 0;
  endtask
  task automatic do_reset();
    rst = 1;
    quiet();
    cyc();
    rst = 0;
  endtask
  task automatic do_ins(int a, logic [LW-1:0] d, bit dt);
    ins_valid_i = 1;
    ins_addr_i = AW'(a);
    ins_data_i = d;
    ins_dirty_i = dt;
    cyc();
    ins_valid_i = 0;
  endtask
  task automatic do_lk(int a);
    lookup_req_i = 1;
    lookup_addr_i = AW'(a);
    cyc();
    lookup_req_i = 0;
  endtask
  initial begin
    int d0, h0;
    quiet();
    lookup_addr_i = '0;
    ins_addr_i = '0;
    ins_data_i = '0;
    ins_dirty_i = 0;
    wb_ready_i = 0;
    do_reset();
    do_reset();
    chk("rst_ready", LW'(ins_ready_o), LW'(1));
    chk("rst_occ", LW'(occupancy_o), '0);
    // swap-out on hit, then a second lookup misses
    do_ins(32'h100, {16{8'hAA}}, 1);
    chk("t1_occ_ins", LW'(occupancy_o), LW'(1));
    do_lk(32'h100);
    chk("t1_hit", LW'(lookup_hit_o), LW'(1));
    chk("t1_dirty", LW'(lookup_dirty_o), LW'(1));
    chk("t1_data", lookup_data_o, {16{8'hAA}});
    chk("t1_occ", LW'(occupancy_o), '0);
    do_lk(32'h100);
    chk("t1_rehit", LW'(lookup_hit_o), '0);
    // clean FIFO replacement
    do_reset();
    for (int k = 0; k < N; k++) do_ins(32'h10 + k, LW'(32'h1000 + k), 0);
    do_ins(32'h14, LW'(32'h1004), 0);
    chk("t2_occ", LW'(occupancy_o), LW'(4));
    chk("t2_wb", LW'(wb_valid_o), '0);
    do_lk(32'h10);
    chk("t2_slot0_gone", LW'(lookup_hit_o), '0);
    do_ins(32'h15, LW'(32'h1005), 0);
    do_lk(32'h11);
    chk("t2_ptr1_gone", LW'(lookup_hit_o), '0);
    do_lk(32'h12);
    chk("t2_slot2_kept", LW'(lookup_hit_o), LW'(1));
    // dirty victim stalls inserts until memory accepts it
    do_reset();
    for (int k = 0; k < N; k++) do_ins(32'h20 + k, LW'(32'hC0DE_0000 + k), 1);
    do_ins(32'h24, LW'(32'hC0DE_0004), 1);
    cyc();
    chk("t3_wb_valid", LW'(wb_valid_o), LW'(1));
    chk("t3_wb_addr", LW'(wb_addr_o), LW'(32'h20));
    chk("t3_wb_data", wb_data_o, LW'(32'hC0DE_0000));
    chk("t3_ready", LW'(ins_ready_o), '0);
    wb_ready_i = 1;
    cyc();
    wb_ready_i = 0;
    chk("t3_wb_clr", LW'(wb_valid_o), '0);
    chk("t3_ready_back", LW'(ins_ready_o), LW'(1));
    // flush writes back entries 1 and 3 only
    do_reset();
    for (int k = 0; k < N; k++) do_ins(32'h30 + k, LW'(32'hF000 + k), k[0]);
    wb_ready_i = 1;
    d0 = done_count;
    h0 = hs_count;
    hs_log.delete();
    flush_i = 1;
    cyc();
    flush_i = 0;
    for (int i = 0; i < 100 && done_count == d0; i++) cyc();
    cyc();
    chk("t4_done", LW'(done_count - d0), LW'(1));
    chk("t4_wbs", LW'(hs_count - h0), LW'(2));
    if (hs_log.size() == 2) begin
      chk("t4_wb0", LW'(hs_log[0]), LW'(32'h31));
      chk("t4_wb1", LW'(hs_log[1]), LW'(32'h33));
    end
    chk("t4_occ", LW'(occupancy_o), '0);
    wb_ready_i = 0;
    // swap: lookup hit and full-cache insert in one cycle
    do_reset();
    for (int k = 0; k < N; k++) do_ins(32'h200 + k, LW'(32'hB000 + k), 1);
    lookup_req_i = 1;
    lookup_addr_i = AW'(32'h200);
    do_ins(32'h300, LW'(32'hB300), 1);
    lookup_req_i = 0;
    chk("t5_hit", LW'(lookup_hit_o), LW'(1));
    chk("t5_occ", LW'(occupancy_o), LW'(4));
    chk("t5_nowb", LW'(wb_valid_o), '0);
    do_lk(32'h300);
    chk("t5_new", lookup_data_o, LW'(32'hB300));
    // reset in the middle of a flush writeback
    do_reset();
    do_ins(32'h40, LW'(32'hA0), 1);
    do_ins(32'h41, LW'(32'hA1), 1);
    flush_i = 1;
    cyc();
    flush_i = 0;
    for (int i = 0; i < 3; i++) cyc();
    chk("t6_pending", LW'(wb_valid_o), LW'(1));
    do_reset();
    chk("t6_wb", LW'(wb_valid_o), '0);
    chk("t6_occ", LW'(occupancy_o), '0);
    chk("t6_ready", LW'(ins_ready_o), LW'(1));
    do_lk(32'h41);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      lookup_req_i = $urandom_range(0, 9) < 4;
      lookup_addr_i = AW'(32'h400 + $urandom_range(0, 5));
      ins_valid_i = $urandom_range(0, 1) == 1;
      ins_addr_i = AW'(32'h400 + $urandom_range(0, 5));
      ins_data_i = {$urandom(), $urandom(), $urandom(), $urandom()};
      ins_dirty_i = $urandom_range(0, 1) == 1;
      wb_ready_i = $urandom_range(0, 1) == 1;
      flush_i = !flushing && $urandom_range(0, 49) == 0;
      cyc();
    end
    quiet();
    wb_ready_i = 1;
    for (int i = 0; i < 20; i++) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
